// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS write-back stage.
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned NUM_REG = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    localparam int unsigned SYSCALL_HALT = 10;
    localparam int unsigned SYSCALL_DISP = 34;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef enum logic [0:0] {
        RUN  = ST_RUN,
        HALT = ST_HALT
    } wb_state_t;

    // Effective GPR write presented by the write-back stage.
    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] num;
        logic [XLEN-1:0]  data;
    } wb_write_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 GPR file: one synchronous write port, two asynchronous read ports with
// same-cycle write-through bypass; $0 is hardwired to zero.
module regfile_2r1w
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  wb_write_t        wr,
    input  logic [REG_W-1:0] ra_addr,
    input  logic [REG_W-1:0] rb_addr,
    output logic [XLEN-1:0]  ra_data,
    output logic [XLEN-1:0]  rb_data
);

    logic [XLEN-1:0] mem [NUM_REG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REG); i++) begin
                mem[i] <= '0;
            end
        end else if (wr.we && (wr.num != REG_ZERO)) begin
            mem[wr.num] <= wr.data;
        end
    end

    // Read with $0 forcing and bypass of the write landing this cycle.
    always_comb begin
        ra_data = mem[ra_addr];
        rb_data = mem[rb_addr];
        if (wr.we && (ra_addr == wr.num)) ra_data = wr.data;
        if (wr.we && (rb_addr == wr.num)) rb_data = wr.data;
        if (ra_addr == REG_ZERO) ra_data = '0;
        if (rb_addr == REG_ZERO) rb_data = '0;
    end

endmodule

// File: rtl/wb_writeback_unit.sv
// MIPS write-back stage: commits MEM/WB results into the GPR file and HI/LO,
// runs the SYSCALL halt/display logic and counts retired instructions.
module wb_writeback_unit
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned HALT_CODE = SYSCALL_HALT,
    parameter int unsigned DISP_CODE = SYSCALL_DISP
) (
    input  logic             clk,
    input  logic             CLR_n,
    input  logic             wb_valid,
    input  logic [31:0]      IR,
    input  logic [31:0]      PC,
    input  logic [31:0]      R1,
    input  logic [31:0]      R2,
    input  logic [31:0]      RD1,
    input  logic [31:0]      RD2,
    input  logic [4:0]       WbRegNum,
    input  logic             RegWrite,
    input  logic             LOWrite,
    input  logic             HIWrite,
    input  logic             JAL,
    input  logic             SYSCALL,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      hi,
    output logic [31:0]      lo,
    output logic             wb_we,
    output logic [4:0]       wb_num,
    output logic [31:0]      wb_data,
    output logic             halt,
    output logic             disp_valid,
    output logic [31:0]      disp_data,
    output logic [CNT_W-1:0] retired
);

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       commit_c;
    logic       sys_halt_c;
    logic       sys_disp_c;
    wb_write_t  wr;

    // The instruction word travels down the pipe for debug only.
    logic unused_ir;
    assign unused_ir = ^IR;

    assign commit_c   = wb_valid && (state_q == ST_RUN);
    assign sys_halt_c = commit_c && SYSCALL && (RD1 == 32'(HALT_CODE));
    assign sys_disp_c = commit_c && SYSCALL && (RD1 == 32'(DISP_CODE));

    assign wb_data = JAL ? (PC + 32'd4) : R1;
    assign wb_num  = WbRegNum;
    assign wb_we   = commit_c && RegWrite && (WbRegNum != REG_ZERO);

    assign wr.we   = wb_we;
    assign wr.num  = wb_num;
    assign wr.data = wb_data;

    regfile_2r1w u_regfile (
        .clk     (clk),
        .rst_n   (CLR_n),
        .wr      (wr),
        .ra_addr (rs_addr),
        .rb_addr (rt_addr),
        .ra_data (rs_data),
        .rb_data (rt_data)
    );

    always_ff @(posedge clk) begin
        if (!CLR_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (sys_halt_c) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    assign halt = (state_q == ST_HALT);

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            hi         <= '0;
            lo         <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            retired    <= '0;
        end else begin
            if (commit_c && LOWrite) lo <= R1;
            if (commit_c && HIWrite) hi <= R2;
            if (commit_c) retired <= retired + CNT_W'(1);
            disp_valid <= sys_disp_c;
            if (sys_disp_c) disp_data <= RD2;
        end
    end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed self-checking bench for wb_writeback_unit.
module tb_wb_writeback_unit;

    logic        clk = 1'b0;
    logic        CLR_n;
    logic        wb_valid;
    logic [31:0] IR, PC, R1, R2, RD1, RD2;
    logic [4:0]  WbRegNum;
    logic        RegWrite, LOWrite, HIWrite, JAL, SYSCALL;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, hi, lo, wb_data, disp_data, retired;
    logic [4:0]  wb_num;
    logic        wb_we, halt, disp_valid;

    int n_checks = 0;
    int n_errors = 0;

    wb_writeback_unit dut (
        .clk(clk), .CLR_n(CLR_n), .wb_valid(wb_valid), .IR(IR), .PC(PC),
        .R1(R1), .R2(R2), .RD1(RD1), .RD2(RD2), .WbRegNum(WbRegNum),
        .RegWrite(RegWrite), .LOWrite(LOWrite), .HIWrite(HIWrite), .JAL(JAL),
        .SYSCALL(SYSCALL), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .hi(hi), .lo(lo),
        .wb_we(wb_we), .wb_num(wb_num), .wb_data(wb_data), .halt(halt),
        .disp_valid(disp_valid), .disp_data(disp_data), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bubble();
        wb_valid = 1'b0; IR = 32'h0; PC = 32'h0; R1 = 32'h0; R2 = 32'h0;
        RD1 = 32'h0; RD2 = 32'h0; WbRegNum = 5'd0; RegWrite = 1'b0;
        LOWrite = 1'b0; HIWrite = 1'b0; JAL = 1'b0; SYSCALL = 1'b0;
    endtask

    // Advance one clock and sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic syscall(input logic [31:0] code, input logic [31:0] arg);
        bubble();
        wb_valid = 1'b1; SYSCALL = 1'b1; RD1 = code; RD2 = arg;
    endtask

    initial begin
        bubble();
        rs_addr = 5'd5; rt_addr = 5'd31;
        CLR_n = 1'b0;
        step(); step();
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_rs5", rs_data, 32'd0);
        CLR_n = 1'b1;

        // Write $5 with same-cycle bypass
        wb_valid = 1'b1; RegWrite = 1'b1; WbRegNum = 5'd5; R1 = 32'h1234;
        #1;
        check("t1_wb_we", 32'(wb_we), 32'd1);
        check("t1_wb_num", 32'(wb_num), 32'd5);
        check("t1_bypass", rs_data, 32'h1234);
        step(); bubble();
        #1;
        check("t1_stored", rs_data, 32'h1234);
        check("t1_retired", retired, 32'd1);

        // Write to $0 is dropped but still retires
        wb_valid = 1'b1; RegWrite = 1'b1; WbRegNum = 5'd0; R1 = 32'hFFFF_FFFF;
        rs_addr = 5'd0;
        #1;
        check("t2_wb_we", 32'(wb_we), 32'd0);
        check("t2_r0_bypass", rs_data, 32'd0);
        step(); bubble();
        #1;
        check("t2_r0", rs_data, 32'd0);
        check("t2_retired", retired, 32'd2);

        // Bubble with RegWrite set does nothing
        RegWrite = 1'b1; WbRegNum = 5'd6; R1 = 32'h77; rs_addr = 5'd6;
        #1;
        check("t6_bubble_we", 32'(wb_we), 32'd0);
        check("t6_bubble_bypass", rs_data, 32'd0);
        step(); bubble();
        #1;
        check("t6_bubble_r6", rs_data, 32'd0);
        check("t6_bubble_retired", retired, 32'd2);

        // JAL writes PC+4, including wrap
        wb_valid = 1'b1; RegWrite = 1'b1; JAL = 1'b1; WbRegNum = 5'd31;
        PC = 32'h0040_0010; R1 = 32'hDEAD_BEEF;
        #1;
        check("t3_jal_wb_data", wb_data, 32'h0040_0014);
        step();
        check("t3_jal_r31", rt_data, 32'h0040_0014);
        PC = 32'hFFFF_FFFC;
        step(); bubble();
        #1;
        check("t3_jal_wrap", rt_data, 32'h0000_0000);
        check("t3_retired", retired, 32'd4);

        // HI/LO together
        wb_valid = 1'b1; LOWrite = 1'b1; HIWrite = 1'b1;
        R1 = 32'hAAAA_0000; R2 = 32'h0000_5555;
        step(); bubble();
        #1;
        check("t4_lo", lo, 32'hAAAA_0000);
        check("t4_hi", hi, 32'h0000_5555);
        check("t4_retired", retired, 32'd5);

        // Display syscall pulses once
        syscall(32'd34, 32'd7);
        step(); bubble();
        #1;
        check("t5_disp_valid", 32'(disp_valid), 32'd1);
        check("t5_disp_data", disp_data, 32'd7);
        check("t5_disp_halt", 32'(halt), 32'd0);
        step();
        check("t5_disp_drop", 32'(disp_valid), 32'd0);
        check("t5_disp_hold", disp_data, 32'd7);
        check("t5_retired", retired, 32'd6);

        // Back-to-back display syscalls
        syscall(32'd34, 32'd8);
        step();
        check("t5_b2b_v1", 32'(disp_valid), 32'd1);
        check("t5_b2b_d1", disp_data, 32'd8);
        syscall(32'd34, 32'd9);
        step();
        check("t5_b2b_v2", 32'(disp_valid), 32'd1);
        check("t5_b2b_d2", disp_data, 32'd9);

        // Other code: retires only
        syscall(32'd4, 32'd99);
        step();
        check("t5_other_valid", 32'(disp_valid), 32'd0);
        check("t5_other_data", disp_data, 32'd9);
        check("t5_other_halt", 32'(halt), 32'd0);
        check("t5_other_retired", retired, 32'd9);

        // Halt syscall retires and halts
        syscall(32'd10, 32'd0);
        step(); bubble();
        #1;
        check("t5_halt", 32'(halt), 32'd1);
        check("t5_halt_retired", retired, 32'd10);
        check("t5_halt_disp", 32'(disp_valid), 32'd0);

        // Writes ignored while halted
        wb_valid = 1'b1; RegWrite = 1'b1; WbRegNum = 5'd3; R1 = 32'h55;
        LOWrite = 1'b1; rs_addr = 5'd3;
        #1;
        check("t5_halted_we", 32'(wb_we), 32'd0);
        step();
        syscall(32'd34, 32'd5);
        step(); bubble();
        #1;
        check("t5_halted_r3", rs_data, 32'd0);
        check("t5_halted_lo", lo, 32'hAAAA_0000);
        check("t5_halted_retired", retired, 32'd10);
        check("t5_halted_disp", 32'(disp_valid), 32'd0);
        check("t5_halted_sticky", 32'(halt), 32'd1);

        // Reset while halted restarts everything
        rs_addr = 5'd5; rt_addr = 5'd31;
        CLR_n = 1'b0;
        step();
        check("t6_rst_halt", 32'(halt), 32'd0);
        check("t6_rst_retired", retired, 32'd0);
        check("t6_rst_hi", hi, 32'd0);
        check("t6_rst_lo", lo, 32'd0);
        check("t6_rst_r5", rs_data, 32'd0);
        check("t6_rst_disp", disp_data, 32'd0);
        CLR_n = 1'b1;

        // Runs again after reset
        wb_valid = 1'b1; RegWrite = 1'b1; WbRegNum = 5'd5; R1 = 32'hCAFE;
        step(); bubble();
        #1;
        check("t6_post_r5", rs_data, 32'hCAFE);
        check("t6_post_retired", retired, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
